// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO control in front of a single-port RAM.
// One RAM access per cycle, push wins over pop when both are requested.
module ram_fifo_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop,
    output logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_pop_data;
    logic                r_pop_valid;
    logic                w_full;
    logic                w_empty;
    logic                w_push_acc;
    logic                w_pop_acc;

    assign w_full     = (r_count == CNT_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push_acc = push && !w_full;
    assign w_pop_acc  = pop && !w_empty && !w_push_acc;

    assign push_ready = !w_full;
    assign pop_ready  = !w_empty && !w_push_acc;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;
    assign ram_cs     = (r_state != IDLE);
    assign ram_we     = (r_state == WRITE);
    assign ram_addr   = r_addr;
    assign ram_wdata  = r_wdata;
    assign pop_data   = r_pop_data;
    assign pop_valid  = r_pop_valid;

    // Access state register; reset drops ram_cs without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next access: push has priority, otherwise pop, otherwise idle.
    always_comb begin
        w_state_nxt = IDLE;
        if (w_push_acc) begin
            w_state_nxt = WRITE;
        end else if (w_pop_acc) begin
            w_state_nxt = READ;
        end
    end

    // Register RAM address/write data at acceptance so they are stable all cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_push_acc) begin
            r_addr  <= r_wr_ptr;
            r_wdata <= push_data;
        end else if (w_pop_acc) begin
            r_addr  <= r_rd_ptr;
        end
    end

    // Pointers advance at acceptance and wrap naturally at the RAM depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy; accepts are mutually exclusive so at most one step per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_push_acc) begin
            r_count <= r_count + CNT_ONE;
        end else if (w_pop_acc) begin
            r_count <= r_count - CNT_ONE;
        end
    end

    // Capture read data at the end of a READ cycle and strobe it for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= (r_state == READ);
            if (r_state == READ) begin
                r_pop_data <= ram_rdata;
            end
        end
    end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the FIFO word width to match the RAM data width.
REQ-002 Parameter ADDR_W, default 4, SHALL set the RAM address width; FIFO depth SHALL be 2**ADDR_W (16).
REQ-003 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 Port push  input  1  SHALL be the write request from the producer.
REQ-006 Port push_data  input  DATA_W  SHALL be the word to enqueue.
REQ-007 Port push_ready  output  1  SHALL indicate that a push is accepted this cycle.
REQ-008 Port pop  input  1  SHALL be the read request from the consumer.
REQ-009 Port pop_ready  output  1  SHALL indicate that a pop is accepted this cycle.
REQ-010 Port pop_data  output  DATA_W  SHALL be the dequeued word.
REQ-011 Port pop_valid  output  1  SHALL be a one-cycle strobe qualifying pop_data.
REQ-012 Port full  output  1  SHALL be high when count equals 16.
REQ-013 Port empty  output  1  SHALL be high when count equals 0.
REQ-014 Port count  output  ADDR_W+1  SHALL be the number of stored words, 0..16.
REQ-015 Port ram_cs  output  1  SHALL drive the RAM chip select.
REQ-016 Port ram_we  output  1  SHALL drive the RAM write enable.
REQ-017 Port ram_addr  output  ADDR_W  SHALL drive the RAM address.
REQ-018 Port ram_wdata  output  DATA_W  SHALL drive the RAM write data.
REQ-019 Port ram_rdata  input  DATA_W  SHALL receive the RAM read data; it is combinational and valid while ram_cs=1 and ram_we=0.

Function
REQ-020 push_ready SHALL equal !full (combinational).
REQ-021 pop_ready SHALL equal !empty && !(push && push_ready); push SHALL win when both are requested in the same cycle.
REQ-022 The access FSM SHALL have the states IDLE, WRITE and READ, all registered.
REQ-023 FSM transitions SHALL be evaluated every edge: an accepted push SHALL go to WRITE; else an accepted pop SHALL go to READ; else the FSM SHALL go to IDLE.
REQ-024 ram_cs SHALL be (state!=IDLE), and ram_we SHALL be (state==WRITE); both SHALL come directly from the state register.
REQ-025 On an accepted push at edge N: ram_addr SHALL be set to wr_ptr and ram_wdata to push_data, both registered and valid during cycle N..N+1; the RAM write SHALL occur at edge N+1.
REQ-026 On an accepted pop at edge N: ram_addr SHALL be set to rd_ptr; at edge N+1, ram_rdata SHALL be captured into pop_data and pop_valid SHALL go high for exactly one cycle.
REQ-027 wr_ptr and rd_ptr SHALL be ADDR_W bits wide, SHALL increment at acceptance, and SHALL wrap from 15 to 0.
REQ-028 count SHALL increment on an accepted push and decrement on an accepted pop at the acceptance edge; it SHALL never exceed 16 or go below 0.
REQ-029 A pop accepted one edge after the push that made count=1 SHALL return that pushed word; the write at edge N+1 precedes the combinational read in cycle N+1..N+2.
REQ-030 Back-to-back accesses SHALL sustain one accepted request per cycle with no idle cycle.
REQ-031 push while full, or pop while empty, SHALL be ignored with no change to state, pointers, count or RAM.
REQ-032 pop_data SHALL hold its last value when pop_valid=0.

Reset
REQ-033 While rst_n=0, the block SHALL hold: state=IDLE, ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0, wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, pop_data=0, pop_valid=0.
REQ-034 Assertion of rst_n mid-access SHALL abandon the in-flight access immediately, driving ram_cs=0 asynchronously; any pending pop_valid SHALL be dropped.
REQ-035 After rst_n deasserts, the first request SHALL be accepted at the first rising edge.

Verification
REQ-036 Reset then push 0xA -> ram_cs=1, ram_we=1, ram_addr=0, ram_wdata=0xA for one cycle; count=1, empty=0.
REQ-037 Push 0x1..0x6, then pop 6 times -> pop_valid pulses, each one edge after its pop is accepted, with pop_data 0x1..0x6 in order; empty=1 at the end.
REQ-038 Push 16 words -> full=1, push_ready=0; a 17th push is ignored (count stays 16, no ram_cs); 16 pops return all words; rd_ptr wraps to 0.
REQ-039 With count=3, push and pop asserted together -> push is accepted, pop_ready=0, count=4, and the FSM state is WRITE.
REQ-040 Push 0x5 at edge N, pop at edge N+1 -> pop_data=0x5 with pop_valid=1 after edge N+2.
REQ-041 Assert rst_n=0 during a READ cycle -> ram_cs drops without waiting for a clock edge, no pop_valid is issued, count=0 and empty=1.
